// File: rtl/alu_regfile_core.sv
// ---------------------------------------------------------------------------
// alu_regfile_core
//
// Accumulator-style ALU with a small register file. R0 is the accumulator
// (operand A and write-back target); operand B is R[sel]. Load commands
// complete in one edge. ALU commands run IDLE -> EXEC -> WB (3 edges from
// accept to done). New commands are ignored while busy.
//
// Optional feature macro: ALU_REGFILE_MUL_EN
//   defined   : op 11 is a shift-add unsigned multiply that spends WIDTH
//               cycles in state MUL, writes the low half to R0 and the high
//               half to R1 (latency WIDTH+3 edges).
//   undefined : op 11 is a NOP and no multiplier logic exists.
//
// Parameters
//   WIDTH  datapath / register width (4..32)
//   NREG   number of registers, power of two (2..16)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   data_in    load data
//   sel        register select (load target / operand B)
//   op         operation code (ALU commands only)
//   cin        carry/borrow in
//   load       1 = load command, 0 = ALU command
//   ce         command strobe
//   busy       ALU command in flight
//   done       one-cycle pulse on write-back
//   data_out   current R0
//   carry_flag carry/borrow from last flag-updating op
//   zero_flag  last written-back R0 is zero
// ---------------------------------------------------------------------------
module alu_regfile_core #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  localparam int SELW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SELW-1:0]  sel,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic             load,
  input  logic             ce,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_flag,
  output logic             zero_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
`ifdef ALU_REGFILE_MUL_EN
    , ST_MUL = 2'd3
`endif
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [WIDTH-1:0] regs_r [NREG];
  logic [SELW-1:0]  sel_r;
  logic [3:0]       op_r;
  logic             cin_r;
  logic [WIDTH-1:0] result_r;
  logic             res_carry_r;
  logic             done_r;
  logic             carry_r;
  logic             zero_r;

  logic             accept_alu_s;
  logic             accept_load_s;
  logic             busy_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic [WIDTH:0]   wide_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;

`ifdef ALU_REGFILE_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      mul_cnt_r;
  logic [WIDTH:0]     mul_sum_s;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_alu_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
`ifdef ALU_REGFILE_MUL_EN
        if (op_r == 4'd11) begin
          state_s = ST_MUL;
        end else begin
          state_s = ST_WB;
        end
`else
        state_s = ST_WB;
`endif
      end
      ST_WB: state_s = ST_IDLE;
`ifdef ALU_REGFILE_MUL_EN
      ST_MUL: begin
        if (mul_cnt_r == CW'(WIDTH - 1)) begin
          state_s = ST_WB;
        end else begin
          state_s = ST_MUL;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Command qualification and status decode
  always_comb begin
    busy_s        = (state_r != ST_IDLE);
    accept_load_s = !busy_s && ce && load;
    accept_alu_s  = !busy_s && ce && !load;
  end

  assign busy       = busy_s;
  assign done       = done_r;
  assign data_out   = regs_r[0];
  assign carry_flag = carry_r;
  assign zero_flag  = zero_r;

  // ALU: A is always the accumulator, B the latched register select
  always_comb begin
    opa_s       = regs_r[0];
    opb_s       = regs_r[sel_r];
    wide_s      = {(WIDTH+1){1'b0}};
    alu_res_s   = opa_s;
    alu_carry_s = carry_r;
    case (op_r)
      4'd0: begin
        wide_s      = {1'b0, opa_s} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin_r};
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
      end
      4'd1: begin
        // Bit WIDTH of the extended difference is the borrow
        wide_s      = {1'b0, opa_s} - {1'b0, opb_s} - {{WIDTH{1'b0}}, cin_r};
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
      end
      4'd2: begin alu_res_s = opa_s & opb_s; alu_carry_s = 1'b0; end
      4'd3: begin alu_res_s = opa_s | opb_s; alu_carry_s = 1'b0; end
      4'd4: begin alu_res_s = opa_s ^ opb_s; alu_carry_s = 1'b0; end
      4'd5: begin alu_res_s = ~opa_s;        alu_carry_s = 1'b0; end
      4'd6: begin
        alu_res_s   = {opa_s[WIDTH-2:0], cin_r};
        alu_carry_s = opa_s[WIDTH-1];
      end
      4'd7: begin
        alu_res_s   = {cin_r, opa_s[WIDTH-1:1]};
        alu_carry_s = opa_s[0];
      end
      4'd8: begin alu_res_s = opb_s; alu_carry_s = 1'b0; end
      4'd9: begin
        wide_s      = {1'b0, opa_s} + {{WIDTH{1'b0}}, 1'b1};
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
      end
      4'd10: begin
        wide_s      = {1'b0, opa_s} - {{WIDTH{1'b0}}, 1'b1};
        alu_res_s   = wide_s[WIDTH-1:0];
        alu_carry_s = wide_s[WIDTH];
      end
      // 11 (multiply is handled separately) and 12..15: keep R0 and carry
      default: begin
        alu_res_s   = opa_s;
        alu_carry_s = carry_r;
      end
    endcase
  end

`ifdef ALU_REGFILE_MUL_EN
  // Partial-product add for one shift-add step (A = accumulator)
  always_comb begin
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, regs_r[0]};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
  end

  // Shift-add multiplier: product high half accumulates, multiplier shifts out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r    <= {(2*WIDTH){1'b0}};
      mul_cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_EXEC) begin
      prod_r    <= {{WIDTH{1'b0}}, opb_s};
      mul_cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_MUL) begin
      prod_r    <= {mul_sum_s, prod_r[WIDTH-1:1]};
      mul_cnt_r <= mul_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      prod_r    <= prod_r;
      mul_cnt_r <= mul_cnt_r;
    end
  end
`endif

  // Command latch, ALU result, register file, flags and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      sel_r       <= {SELW{1'b0}};
      op_r        <= 4'd0;
      cin_r       <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      res_carry_r <= 1'b0;
      done_r      <= 1'b0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      done_r <= (state_r == ST_WB);
      if (accept_alu_s) begin
        sel_r <= sel;
        op_r  <= op;
        cin_r <= cin;
      end
      if (state_r == ST_EXEC) begin
        result_r    <= alu_res_s;
        res_carry_r <= alu_carry_s;
      end
      if (accept_load_s) begin
        regs_r[sel] <= data_in;
      end else if (state_r == ST_WB) begin
`ifdef ALU_REGFILE_MUL_EN
        if (op_r == 4'd11) begin
          regs_r[0] <= prod_r[WIDTH-1:0];
          regs_r[1] <= prod_r[2*WIDTH-1:WIDTH];
          carry_r   <= (prod_r[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          zero_r    <= (prod_r[WIDTH-1:0] == {WIDTH{1'b0}});
        end else begin
          regs_r[0] <= result_r;
          carry_r   <= res_carry_r;
          zero_r    <= (result_r == {WIDTH{1'b0}});
        end
`else
        regs_r[0] <= result_r;
        carry_r   <= res_carry_r;
        zero_r    <= (result_r == {WIDTH{1'b0}});
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_core.sv
// ---------------------------------------------------------------------------
// tb_alu_regfile_core
//
// Scoreboard bench for alu_regfile_core (WIDTH=8, NREG=8). The driver keeps
// an arithmetic reference model of the register file and flags; each accepted
// ALU command pushes its expected R0/flags and completion cycle into a queue,
// and an independent monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_regfile_core;

  localparam int W    = 8;
  localparam int NR   = 8;
  localparam int SW   = 3;
  localparam int MOD  = 256;

  logic          clk;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [SW-1:0] sel;
  logic [3:0]    op;
  logic          cin;
  logic          load;
  logic          ce;
  logic          busy;
  logic          done;
  logic [W-1:0]  data_out;
  logic          carry_flag;
  logic          zero_flag;

  alu_regfile_core #(.WIDTH(W), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .op(op), .cin(cin),
    .load(load), .ce(ce), .busy(busy), .done(done), .data_out(data_out),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  typedef struct {
    int r0;
    int c;
    int z;
    int cy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ign    = 0;
  int   ref_regs [NR];
  int   ref_c    = 0;
  int   ref_z    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("done_cycle", cyc, mon_e.cy);
        chk("wb_data_out", int'(data_out), mon_e.r0);
        chk("wb_carry", int'(carry_flag), mon_e.c);
        chk("wb_zero", int'(zero_flag), mon_e.z);
      end
    end
  end

  // Reference behaviour of one accepted ALU command
  task automatic model_alu(input int o, input int s, input int ci);
    int a, b, r, c, lat, t;
    a = ref_regs[0];
    b = ref_regs[s];
    r = a;
    c = ref_c;
    lat = 3;
    case (o)
      0: begin t = a + b + ci; r = t % MOD; c = (t >= MOD); end
      1: begin t = a - b - ci; r = (t + 2 * MOD) % MOD; c = (a < b + ci); end
      2: begin r = a & b; c = 0; end
      3: begin r = a | b; c = 0; end
      4: begin r = a ^ b; c = 0; end
      5: begin r = (MOD - 1) - a; c = 0; end
      6: begin r = (a * 2 + ci) % MOD; c = (a >= MOD / 2); end
      7: begin r = a / 2 + ci * (MOD / 2); c = a % 2; end
      8: begin r = b; c = 0; end
      9: begin r = (a + 1) % MOD; c = (a == MOD - 1); end
      10: begin r = (a + MOD - 1) % MOD; c = (a == 0); end
`ifdef ALU_REGFILE_MUL_EN
      11: begin
        t = a * b;
        r = t % MOD;
        ref_regs[1] = t / MOD;
        c = (t / MOD) != 0;
        lat = W + 3;
      end
`endif
      default: begin r = a; end
    endcase
    ref_regs[0] = r;
    ref_c = c;
    ref_z = (r == 0);
    q.push_back('{r0: r, c: c, z: ref_z, cy: cyc + lat});
    ign = lat - 1;
  endtask

  // One command slot: check status, drive inputs, update the model
  task automatic step(input int c_e, input int ld, input int s, input int d,
                      input int o, input int ci);
    @(negedge clk);
    #1;
    chk("busy", int'(busy), (ign > 0) ? 1 : 0);
    if (ign == 0) begin
      chk("idle_data_out", int'(data_out), ref_regs[0]);
      chk("idle_carry", int'(carry_flag), ref_c);
      chk("idle_zero", int'(zero_flag), ref_z);
    end
    ce      = (c_e != 0);
    load    = (ld != 0);
    sel     = SW'(s);
    data_in = W'(d);
    op      = 4'(o);
    cin     = (ci != 0);
    if (ign > 0) begin
      ign--;
    end else if (c_e != 0) begin
      if (ld != 0) ref_regs[s] = d;
      else model_alu(o, s, ci);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end while (!(ign == 0 && q.size() == 0) && n < 40);
    chk("drain_timeout", (ign == 0 && q.size() == 0) ? 1 : 0, 1);
  endtask

  task automatic expect_out(input string nm, input int d, input int c, input int z);
    chk({nm, "_data_out"}, int'(data_out), d);
    chk({nm, "_carry"}, int'(carry_flag), c);
    chk({nm, "_zero"}, int'(zero_flag), z);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_regs[i] = 0;
    ref_c = 0;
    ref_z = 0;
    ign = 0;
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ce = 1'b0; load = 1'b0; sel = '0; data_in = '0; op = 4'd0; cin = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    expect_out("rst", 0, 0, 0);
    @(negedge clk); #1; rst = 1'b0;

    // 7F + 01
    step(1, 1, 0, 8'h7F, 0, 0);
    step(1, 1, 3, 8'h01, 0, 0);
    step(1, 0, 3, 0, 0, 0);
    drain();
    expect_out("add", 8'h80, 0, 0);

    // INC wraps
    step(1, 1, 0, 8'hFF, 0, 0);
    step(1, 0, 0, 0, 9, 0);
    drain();
    expect_out("inc", 8'h00, 1, 1);

    // SUB with borrow; load during busy must be ignored
    step(1, 1, 0, 8'h05, 0, 0);
    step(1, 1, 2, 8'h07, 0, 0);
    step(1, 0, 2, 0, 1, 0);
    step(1, 1, 2, 8'hAA, 0, 0);
    drain();
    expect_out("sub", 8'hFE, 1, 0);
    step(1, 0, 2, 0, 8, 0);
    drain();
    expect_out("mov_r2", 8'h07, 0, 0);

    // SHR with cin, then NOP
    step(1, 1, 0, 8'h81, 0, 0);
    step(1, 0, 0, 0, 7, 1);
    drain();
    expect_out("shr", 8'hC0, 1, 0);
    step(1, 0, 0, 0, 12, 0);
    drain();
    expect_out("nop", 8'hC0, 1, 0);

    // Multiply (or NOP when the multiplier is not built)
    step(1, 1, 0, 8'h10, 0, 0);
    step(1, 1, 1, 8'h20, 0, 0);
    step(1, 0, 1, 0, 11, 0);
    drain();
`ifdef ALU_REGFILE_MUL_EN
    expect_out("mul", 8'h00, 1, 1);
    step(1, 0, 1, 0, 8, 0);
    drain();
    expect_out("mul_hi", 8'h02, 0, 0);
`else
    expect_out("mul_nop", 8'h10, 1, 0);
`endif

    // sel=0 uses R0 as operand B
    step(1, 1, 0, 8'h40, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    drain();
    expect_out("add_self", 8'h81, 0, 0);

    // Reset during EXEC aborts; load accepted on first edge after release
    step(1, 1, 4, 8'h11, 0, 0);
    step(1, 0, 4, 0, 0, 0);
    @(negedge clk); #1;
    rst = 1'b1; ce = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    expect_out("mid_rst", 0, 0, 0);
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0; ce = 1'b1; load = 1'b1; sel = 3'd0; data_in = 8'h5A;
    ref_regs[0] = 8'h5A;
    drain();
    expect_out("post_rst_load", 8'h5A, 0, 0);

    // Randomized traffic, including commands while busy
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           int'($urandom_range(0, NR - 1)),
           int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)));
    end
    drain();
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
